// File: rtl/ipsxe_floating_point_group3_lo_acc_v1_0.sv
// Iterative shift-add producer of a0lo - a1*y + zgroup2 for the invsqrt group-3 low path.
// Optional build macro IPSXE_FLOATING_POINT_GROUP3_LO_PREADD_RND_EN folds the rounding half 2^(RNE-1) into the sum.
module ipsxe_floating_point_group3_lo_acc_v1_0 #(
    parameter int A1_WIDTH  = 24,
    parameter int Y_WIDTH   = 24,
    parameter int ACC_WIDTH = 48,
    parameter int RNE       = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [ACC_WIDTH-1:0] i_a0lo,
    input  logic [A1_WIDTH-1:0]  i_a1,
    input  logic [Y_WIDTH-1:0]   i_y,
    input  logic [ACC_WIDTH-1:0] i_zgroup2,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [ACC_WIDTH-1:0] o_a0lo_minus_a1y_plus_zgroup2
);

    // state  | meaning
    // IDLE   | ready for operands
    // MUL    | one multiplier bit per cycle, LSB first
    // SUM    | combine product with a0lo and zgroup2
    // DONE   | result held until downstream accepts

    localparam int PROD_W = A1_WIDTH + Y_WIDTH;
    localparam int CNT_W  = $clog2(Y_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(Y_WIDTH - 1);

`ifdef IPSXE_FLOATING_POINT_GROUP3_LO_PREADD_RND_EN
    localparam bit RND_EN = 1'b1;
`else
    localparam bit RND_EN = 1'b0;
`endif
    localparam logic [ACC_WIDTH-1:0] RND_ADD = RND_EN ? (ACC_WIDTH'(1) << (RNE - 1)) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_SUM,
        S_DONE
    } state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] a0lo_q;
    logic [ACC_WIDTH-1:0] zgroup2_q;
    logic [A1_WIDTH-1:0]  a1_q;
    logic [Y_WIDTH-1:0]   y_q;
    logic [PROD_W-1:0]    acc;
    logic [CNT_W-1:0]     cnt;
    logic [PROD_W-1:0]    a1_ext;
    logic [ACC_WIDTH-1:0] prod_ext;

    assign a1_ext = PROD_W'(a1_q);

    // Product is zero-extended or truncated to the accumulator width before the subtraction.
    generate
        if (PROD_W >= ACC_WIDTH) begin : g_prod_trunc
            assign prod_ext = acc[ACC_WIDTH-1:0];
        end else begin : g_prod_zext
            assign prod_ext = {{(ACC_WIDTH - PROD_W){1'b0}}, acc};
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                         <= S_IDLE;
            a0lo_q                        <= '0;
            zgroup2_q                     <= '0;
            a1_q                          <= '0;
            y_q                           <= '0;
            acc                           <= '0;
            cnt                           <= '0;
            o_ready                       <= 1'b1;
            o_valid                       <= 1'b0;
            o_a0lo_minus_a1y_plus_zgroup2 <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        a0lo_q    <= i_a0lo;
                        zgroup2_q <= i_zgroup2;
                        a1_q      <= i_a1;
                        y_q       <= i_y;
                        acc       <= '0;
                        cnt       <= '0;
                        o_ready   <= 1'b0;
                        state     <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (y_q[0]) begin
                        acc <= acc + (a1_ext << cnt);
                    end
                    y_q <= y_q >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state <= S_SUM;
                    end
                end
                S_SUM: begin
                    o_a0lo_minus_a1y_plus_zgroup2 <= a0lo_q - prod_ext + zgroup2_q + RND_ADD;
                    o_valid                       <= 1'b1;
                    state                         <= S_DONE;
                end
                S_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ipsxe_floating_point_group3_lo_acc_v1_0.sv
// Scoreboard bench for ipsxe_floating_point_group3_lo_acc_v1_0 with directed, hand-computed vectors.
module tb_ipsxe_floating_point_group3_lo_acc_v1_0;

`ifdef IPSXE_FLOATING_POINT_GROUP3_LO_PREADD_RND_EN
    localparam logic [47:0] RND = 48'd2;
`else
    localparam logic [47:0] RND = 48'd0;
`endif
    localparam int LATENCY = 25;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [47:0] i_a0lo;
    logic [23:0] i_a1;
    logic [23:0] i_y;
    logic [47:0] i_zgroup2;
    logic        o_valid;
    logic        i_ready;
    logic [47:0] result;

    ipsxe_floating_point_group3_lo_acc_v1_0 dut (
        .i_clk                         (i_clk),
        .i_rst_n                       (i_rst_n),
        .i_valid                       (i_valid),
        .o_ready                       (o_ready),
        .i_a0lo                        (i_a0lo),
        .i_a1                          (i_a1),
        .i_y                           (i_y),
        .i_zgroup2                     (i_zgroup2),
        .o_valid                       (o_valid),
        .i_ready                       (i_ready),
        .o_a0lo_minus_a1y_plus_zgroup2 (result)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc++;

    typedef struct {
        logic [47:0] res;
        int          acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every rising o_valid is matched against the oldest expected entry.
    logic prev_v = 1'b0;
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (o_valid && !prev_v) begin
                if (sb_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_output: got %0h with nothing expected", result);
                end else begin
                    e = sb_q.pop_front();
                    check("result", 64'(result), 64'(e.res));
                    check("latency", 64'(cyc - e.acc_cyc), 64'(LATENCY));
                end
            end
            prev_v = o_valid;
        end
    end

    task automatic issue(input logic [47:0] a0, input logic [23:0] a1, input logic [23:0] y,
                         input logic [47:0] z, input logic [47:0] exp);
        exp_t e;
        int   n = 0;
        @(negedge i_clk);
        while (!o_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) begin
            total_cnt++;
            $display("FAIL ready_timeout: o_ready still %0b after %0d cycles", o_ready, n);
            return;
        end
        i_valid   = 1'b1;
        i_a0lo    = a0;
        i_a1      = a1;
        i_y       = y;
        i_zgroup2 = z;
        @(posedge i_clk);
        #1;
        e.res     = exp;
        e.acc_cyc = cyc;
        sb_q.push_back(e);
        @(negedge i_clk);
        i_valid   = 1'b0;
        i_a0lo    = '1;
        i_a1      = 24'hA5A5A5;
        i_y       = 24'h5A5A5A;
        i_zgroup2 = '1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge i_clk);
            if (sb_q.size() == 0 && !o_valid && o_ready) return;
        end
        total_cnt++;
        $display("FAIL done_timeout: pending=%0d o_valid=%0b o_ready=%0b", sb_q.size(), o_valid, o_ready);
    endtask

    initial begin
        int n;
        exp_t e;
        i_rst_n   = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_a0lo    = '0;
        i_a1      = '0;
        i_y       = '0;
        i_zgroup2 = '0;
        #23;
        check("reset_o_valid", 64'(o_valid), 64'd0);
        check("reset_o_ready", 64'(o_ready), 64'd1);
        check("reset_result", 64'(result), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        issue(48'h1000, 24'd3, 24'd5, 48'h10, 48'h1001 + RND);
        wait_idle();
        issue(48'h0, 24'd1, 24'd1, 48'h0, 48'hFFFF_FFFF_FFFF + RND);
        wait_idle();
        issue(48'hFFFF_FFFF_FFFF, 24'hFFFFFF, 24'hFFFFFF, 48'h0, 48'h0000_01FF_FFFE + RND);
        wait_idle();
        issue(48'd5, 24'd77, 24'd0, 48'd7, 48'd12 + RND);
        wait_idle();

        // Backpressure with a competing request held during DONE.
        i_ready = 1'b0;
        issue(48'h2000, 24'd2, 24'd3, 48'h1, 48'h1FFB + RND);
        n = 0;
        while (!o_valid && n < 60) begin
            @(negedge i_clk);
            n++;
        end
        check("bp_valid_rise", 64'(o_valid), 64'd1);
        i_valid   = 1'b1;
        i_a0lo    = 48'h100;
        i_a1      = 24'd4;
        i_y       = 24'd4;
        i_zgroup2 = 48'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            check("bp_hold_valid", 64'(o_valid), 64'd1);
            check("bp_hold_result", 64'(result), 64'(48'h1FFB + RND));
            check("bp_hold_ready", 64'(o_ready), 64'd0);
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("bp_handshake_valid", 64'(o_valid), 64'd0);
        check("bp_handshake_ready", 64'(o_ready), 64'd1);
        @(posedge i_clk);
        #1;
        check("bp_next_accepted", 64'(o_ready), 64'd0);
        e.res     = 48'hF0 + RND;
        e.acc_cyc = cyc;
        sb_q.push_back(e);
        @(negedge i_clk);
        i_valid = 1'b0;
        wait_idle();

        // Asynchronous reset during the tenth multiply iteration.
        issue(48'h1000, 24'd3, 24'd5, 48'h10, 48'h1001 + RND);
        repeat (9) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("midreset_o_valid", 64'(o_valid), 64'd0);
        check("midreset_o_ready", 64'(o_ready), 64'd1);
        check("midreset_result", 64'(result), 64'd0);
        sb_q.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        issue(48'h3000, 24'd16, 24'd16, 48'h20, 48'h2F20 + RND);
        wait_idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ipsxe_floating_point_group3_lo_acc_v1_0.md
# ipsxe_floating_point_group3_lo_acc_v1_0

Sequential producer of the 48-bit pre-round operand `a0lo - a1*y + zgroup2` for the invsqrt group-3 low path. It sits immediately upstream of the group-3 low RNE rounding stage, which consumes its 48-bit output. The block uses an iterative shift-add multiplier (one multiplier bit per cycle) with valid/ready handshakes on both sides, so no APM is spent on this path.

## Interface
Parameters:
- `A1_WIDTH`, default 24: width of unsigned multiplicand `a1`.
- `Y_WIDTH`, default 24: width of unsigned multiplier `y`. This is also the iteration count.
- `ACC_WIDTH`, default 48: width of `a0lo`, `zgroup2`, the product and the result.
- `RNE`, default 2: rounding position used by the downstream stage. Only the pre-add feature reads it.

Ports:
- `i_clk`, input, 1: clock, rising edge.
- `i_rst_n`, input, 1: reset, asynchronous assert, active-low.
- `i_valid`, input, 1: input operands valid.
- `o_ready`, output, 1: block can accept operands.
- `i_a0lo`, input, ACC_WIDTH: minuend base.
- `i_a1`, input, A1_WIDTH: multiplicand.
- `i_y`, input, Y_WIDTH: multiplier.
- `i_zgroup2`, input, ACC_WIDTH: addend.
- `o_valid`, output, 1: result valid.
- `i_ready`, input, 1: downstream accepts the result.
- `o_a0lo_minus_a1y_plus_zgroup2`, output, ACC_WIDTH: result.

## Operation
- FSM states: IDLE, MUL, SUM, DONE.
- IDLE:
  - `o_ready`=1.
  - On `i_valid`: capture all operands, clear the product accumulator, clear the bit counter, go to MUL.
- MUL, one cycle per bit, LSB first:
  - If the current `y` bit is 1, `acc += a1 << i`.
  - Shift the captured `y` right by one and increment the counter.
  - After Y_WIDTH iterations, go to SUM.
- SUM: `result = a0lo - acc + zgroup2`, mod 2^ACC_WIDTH (two's-complement wrap, no saturation, no flag). Register the result, set `o_valid`=1, go to DONE.
- DONE:
  - Hold `o_valid` and the result stable until `i_ready`=1.
  - On the handshake edge: drop `o_valid`, go to IDLE.
- Product arithmetic: the operands are unsigned. The product accumulator is A1_WIDTH+Y_WIDTH bits and is zero-extended (or truncated) to ACC_WIDTH before the subtraction.
- `i_valid` is ignored outside IDLE. Operand changes after capture have no effect.
- `y`=0 or `a1`=0: all MUL cycles still run. Latency is data-independent.
- Reset, including mid-operation: state=IDLE, accumulator/counter/result cleared, in-flight operation discarded.
- Reset values: `o_ready`=1, `o_valid`=0, `o_a0lo_minus_a1y_plus_zgroup2`=0.

## Timing
- Accept edge is E0 (`i_valid`&`o_ready`=1 at E0).
- MUL iterations occupy edges E1..E(Y_WIDTH).
- SUM at edge E(Y_WIDTH+1). `o_valid` is high after that edge, so latency is Y_WIDTH+1 cycles (25 at defaults).
- `o_ready` is low from after E0 until the edge after the output handshake.
- Output handshake at edge Ek means the next input can be accepted no earlier than edge Ek+1.
- Throughput: one result per Y_WIDTH+3 cycles at best.
- All outputs are registered. There is no combinational path from `i_ready` or `i_valid` to any output.

## Configuration
- Macro `IPSXE_FLOATING_POINT_GROUP3_LO_PREADD_RND_EN`.
- Defined: the SUM state also adds 2^(RNE-1), so the result carries a rounding half and the consumer may truncate bits [RNE-1:0]. This requires RNE ≥ 1.
- Undefined: no constant is added and the result is exactly `a0lo - a1*y + zgroup2`. Rounding is left to the downstream stage.
- Latency and handshake are identical in both builds.

## Test plan
- Basic case, at defaults:
  - Stimulus: `a0lo`=0x1000, `a1`=3, `y`=5, `zgroup2`=0x10.
  - Macro off: `o_valid` rises 25 cycles after accept with result 0x000000001001.
  - Macro on: result 0x000000001003.
- Wrap-around:
  - Stimulus: `a0lo`=0, `a1`=1, `y`=1, `zgroup2`=0.
  - Required: result 0xFFFFFFFFFFFF with no error indication.
- Max operands:
  - Stimulus: `a1`=`y`=0xFFFFFF, `a0lo`=0xFFFFFFFFFFFF, `zgroup2`=0.
  - Required: result 0x000001FFFFFE (product 0xFFFFFE000001).
- Backpressure:
  - Stimulus: `i_ready`=0 for 5 cycles after `o_valid` rises; a new `i_valid` with different operands is held during that time.
  - Required: result and `o_valid` stay stable and `o_ready` stays 0. After `i_ready`=1, the new operands are accepted one cycle later.
- Reset mid-MUL:
  - Stimulus: assert `i_rst_n`=0 at iteration 10.
  - Required: `o_valid`=0, `o_ready`=1, output 0 immediately (asynchronously). After release, the next operation produces the correct value at the full 25-cycle latency.
- Zero multiplier:
  - Stimulus: `y`=0, `a0lo`=5, `zgroup2`=7.
  - Required: result 12, latency still 25 cycles.
